// File: rtl/mul_pkg.sv
// mul_pkg: shared widths, default issue window and FSM state encoding for the HI/LO multiply controller
//   MUL_W            operand width
//   MUL_PW           product width (2*MUL_W)
//   MUL_WAIT_CYCLES  default cycles operands are held before the product is sampled
//   state_e          IDLE / RUN / FIN controller states
package mul_pkg;
  localparam int MUL_W = 32;
  localparam int MUL_PW = 2 * MUL_W;
  localparam int MUL_WAIT_CYCLES = 2 * MUL_W + 1;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;
endpackage

// File: rtl/mul_sign_fix.sv
// mul_sign_fix: operand magnitudes for a signed/unsigned request and conditional negate of the product
//   is_signed  in   1    operands are two's complement
//   op_a/op_b  in   W    raw operands
//   neg        in   1    product must be negated
//   prod       in   2W   unsigned magnitude product
//   abs_a/b    out  W    operand magnitudes (-2^(W-1) maps to 2^(W-1) unsigned)
//   res        out  2W   sign-corrected product
module mul_sign_fix
  import mul_pkg::*;
#(
  parameter int W = MUL_W
) (
  input  logic             is_signed,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  input  logic             neg,
  input  logic [2*W-1:0]   prod,
  output logic [W-1:0]     abs_a,
  output logic [W-1:0]     abs_b,
  output logic [2*W-1:0]   res
);
  assign abs_a = (is_signed && op_a[W-1]) ? -op_a : op_a;
  assign abs_b = (is_signed && op_b[W-1]) ? -op_b : op_b;
  assign res   = neg ? -prod : prod;
endmodule

// File: rtl/mul_hilo_ctrl.sv
// mul_hilo_ctrl: issues operand magnitudes to a free-running shift-add multiplier, samples after a safe window, commits HI/LO
//   clk, rst_n          clock, async active-low reset
//   start, is_signed    multiply request (accepted only when idle), MULT vs MULTU
//   op_a, op_b          operands sampled with start
//   hi_we, lo_we, wdata direct HI/LO writes, honoured only when idle
//   mul_a, mul_b        registered magnitudes to the multiplier, held until next accept
//   mul_p               multiplier magnitude product
//   busy                high from accept edge until commit edge
//   done                one-cycle pulse when new HI/LO first visible
//   hi, lo              architectural HI/LO
module mul_hilo_ctrl
  import mul_pkg::*;
#(
  parameter int W = MUL_W,
  parameter int WAIT_CYCLES = MUL_WAIT_CYCLES
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           is_signed,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  input  logic           hi_we,
  input  logic           lo_we,
  input  logic [W-1:0]   wdata,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_p,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   hi,
  output logic [W-1:0]   lo
);
  localparam int CW = $clog2(WAIT_CYCLES);
  // A shorter window could sample a pass that mixed old and new operands.
  if (WAIT_CYCLES < 2 * W + 1) begin : g_bad_wait
    $error("mul_hilo_ctrl: WAIT_CYCLES must be >= 2*W+1");
  end
  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, abs_a, abs_b;
  logic           neg_q, neg_d, done_q, done_d;
  logic [2*W-1:0] res;
  mul_sign_fix #(.W(W)) u_fix (
    .is_signed(is_signed),
    .op_a(op_a),
    .op_b(op_b),
    .neg(neg_q),
    .prod(mul_p),
    .abs_a(abs_a),
    .abs_b(abs_b),
    .res(res)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        hi_d = hi_we ? wdata : hi_q;
        lo_d = lo_we ? wdata : lo_q;
        if (start) begin
          a_d     = abs_a;
          b_d     = abs_b;
          neg_d   = is_signed & (op_a[W-1] ^ op_b[W-1]);
          cnt_d   = CW'(WAIT_CYCLES - 1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        state_d = (cnt_q == '0) ? S_FIN : S_RUN;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
      end
      S_FIN: begin
        {hi_d, lo_d} = res;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
  assign mul_a = a_q;
  assign mul_b = b_q;
  assign busy  = state_q != S_IDLE;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
endmodule
